bcp_priority_scanner: RTL and testbench



---
 rtl/bcp_priority_scanner.sv | 124 ++++++++++++
 tb/tb_bcp_priority_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcp_priority_scanner.sv
// ============================================================================
//  Module   : bcp_priority_scanner
//  Purpose  : Captures a request vector on start and emits every set-bit index
//             over a valid/ready handshake. Optional macro PE_ROUND_ROBIN_EN
//             switches to round-robin selection.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcp_priority_scanner #(
   parameter  int WIDTH = 8,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             done,
   output logic             none_found
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pending;
   logic [WIDTH-1:0] w_pending_nxt;
   logic             r_zero;
   logic [IDX_W-1:0] w_sel;
   logic             w_hs;

   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      return IDX_W'(v % WIDTH);
   endfunction

`ifdef PE_ROUND_ROBIN_EN
   localparam logic [IDX_W-1:0] c_ptr_rst = IDX_W'(WIDTH - 1);

   logic [IDX_W-1:0] r_ptr;

   // Descending walk so the smallest offset past ptr is the last (winning) write.
   always_comb begin
      w_sel = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (r_pending[wrap_idx(int'(r_ptr) + 1 + i)])
            w_sel = wrap_idx(int'(r_ptr) + 1 + i);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_ptr <= c_ptr_rst;
      else if (!abort && w_hs)
         r_ptr <= w_sel;
   end
`else
   always_comb begin
      w_sel = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (r_pending[wrap_idx(i)])
            w_sel = wrap_idx(i);
      end
   end
`endif

   assign w_hs = (r_state == S_SCAN) && out_ready;

   always_comb begin
      w_pending_nxt = r_pending;
      if (w_hs)
         w_pending_nxt[w_sel] = 1'b0;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = (in_vec == '0) ? S_DONE : S_SCAN;
         S_SCAN: if (w_hs && (w_pending_nxt == '0)) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (abort)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
         r_zero    <= 1'b0;
      end else if (abort) begin
         r_pending <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_pending <= in_vec;
         r_zero    <= (in_vec == '0);
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign out_valid  = (r_state == S_SCAN);
   assign out_idx    = w_sel;
   assign done       = (r_state == S_DONE);
   assign none_found = (r_state == S_DONE) && r_zero;

endmodule

`default_nettype wire

// File: tb/tb_bcp_priority_scanner.sv
// ============================================================================
//  Module   : tb_bcp_priority_scanner
//  Purpose  : Self-checking bench for bcp_priority_scanner (WIDTH 8 and 32).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcp_priority_scanner;

   localparam int W = 8;
`ifdef PE_ROUND_ROBIN_EN
   localparam bit c_rr = 1'b1;
`else
   localparam bit c_rr = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset_n;
   logic [W-1:0] in_vec;
   logic         start, abort, out_ready;
   logic         busy, out_valid, done, none_found;
   logic [2:0]   out_idx;

   logic [31:0]  in_vec32;
   logic         start32, abort32, ready32;
   logic         busy32, valid32, done32, none32;
   logic [4:0]   idx32;

   int n_cmp = 0;
   int n_mis = 0;
   int m_ptr = W - 1;
   int g_obs[$];

   always #5 clock = ~clock;

   bcp_priority_scanner #(.WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n), .in_vec(in_vec), .start(start), .abort(abort),
      .busy(busy), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
      .done(done), .none_found(none_found)
   );

   bcp_priority_scanner #(.WIDTH(32)) dut32 (
      .clock(clock), .reset_n(reset_n), .in_vec(in_vec32), .start(start32), .abort(abort32),
      .busy(busy32), .out_idx(idx32), .out_valid(valid32), .out_ready(ready32),
      .done(done32), .none_found(none32)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Expected grant order: ascending indices, starting after the last grant in round-robin mode.
   task automatic run_scan(input logic [W-1:0] vec, input int stall_first,
                           input int abort_after, input bit rand_ready);
      int  exp_q[$];
      int  base, cyc, grants;
      bit  rdy, aborted;
      base = c_rr ? (m_ptr + 1) : 0;
      for (int off = 0; off < W; off++)
         if (vec[(base + off) % W]) exp_q.push_back((base + off) % W);
      g_obs.delete();
      start = 1'b1; in_vec = vec;
      step();
      start = 1'b0; in_vec = ~vec;
      if (exp_q.size() == 0) begin
         chk_eq("zero_done", done, 1);
         chk_eq("zero_none", none_found, 1);
         chk_eq("zero_valid", out_valid, 0);
         step();
         chk_eq("zero_idle_done", done, 0);
         chk_eq("zero_idle_busy", busy, 0);
         return;
      end
      cyc = 0; grants = 0; aborted = 1'b0;
      while (exp_q.size() > 0 && cyc < 200) begin
         chk_eq("scan_valid", out_valid, 1);
         chk_eq("scan_idx", out_idx, exp_q[0]);
         chk_eq("scan_done", done, 0);
         if (grants == abort_after) begin
            abort = 1'b1; out_ready = 1'b1; start = 1'b0;
            step();
            abort = 1'b0; out_ready = 1'b0;
            chk_eq("abort_valid", out_valid, 0);
            chk_eq("abort_busy", busy, 0);
            chk_eq("abort_done", done, 0);
            aborted = 1'b1;
            break;
         end
         rdy = (cyc < stall_first) ? 1'b0 : (rand_ready ? 1'($urandom % 2) : 1'b1);
         out_ready = rdy;
         start     = 1'($urandom % 2);
         in_vec    = W'($urandom);
         if (rdy) g_obs.push_back(int'(out_idx));
         step();
         cyc++;
         if (rdy) begin
            m_ptr = exp_q[0];
            void'(exp_q.pop_front());
            grants++;
         end
      end
      out_ready = 1'b0; start = 1'b0;
      if (cyc >= 200) chk_eq("scan_timeout", 0, 1);
      if (!aborted) begin
         chk_eq("end_done", done, 1);
         chk_eq("end_none", none_found, 0);
         chk_eq("end_valid", out_valid, 0);
         step();
         chk_eq("end_idle_done", done, 0);
         chk_eq("end_idle_busy", busy, 0);
      end
   endtask

   initial begin
      reset_n = 1'b0; in_vec = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      in_vec32 = '0; start32 = 1'b0; abort32 = 1'b0; ready32 = 1'b0;
      step(); step();
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_valid", out_valid, 0);
      chk_eq("rst_idx", out_idx, 0);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_none", none_found, 0);
      reset_n = 1'b1;
      step();

      // Asynchronous reset in the middle of a scan
      start = 1'b1; in_vec = 8'hFF;
      step();
      start = 1'b0;
      chk_eq("t1_valid_pre", out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk_eq("t1_busy", busy, 0);
      chk_eq("t1_valid", out_valid, 0);
      chk_eq("t1_done", done, 0);
      #2 reset_n = 1'b1;
      m_ptr = W - 1;
      step();

      run_scan(8'b1010_0100, 0, -1, 1'b0);
      chk_eq("t2_n", g_obs.size(), 3);
      if (g_obs.size() == 3) begin
         chk_eq("t2_0", g_obs[0], 2);
         chk_eq("t2_1", g_obs[1], 5);
         chk_eq("t2_2", g_obs[2], 7);
      end

      run_scan(8'h00, 0, -1, 1'b0);

      run_scan(8'h81, 3, -1, 1'b0);
      chk_eq("t4_n", g_obs.size(), 2);
      if (g_obs.size() == 2) begin
         chk_eq("t4_0", g_obs[0], 0);
         chk_eq("t4_1", g_obs[1], 7);
      end

      run_scan(8'hFF, 0, 2, 1'b0);
      run_scan(8'h10, 0, -1, 1'b0);
      chk_eq("t5_n", g_obs.size(), 1);
      if (g_obs.size() == 1) chk_eq("t5_0", g_obs[0], 4);

      run_scan(8'h06, 0, -1, 1'b0);
      chk_eq("t6a_n", g_obs.size(), 2);
      if (g_obs.size() == 2) begin
         chk_eq("t6a_0", g_obs[0], 1);
         chk_eq("t6a_1", g_obs[1], 2);
      end
      run_scan(8'h0B, 0, -1, 1'b0);
      chk_eq("t6b_n", g_obs.size(), 3);
      if (g_obs.size() == 3) begin
         chk_eq("t6b_0", g_obs[0], c_rr ? 3 : 0);
         chk_eq("t6b_1", g_obs[1], c_rr ? 0 : 1);
         chk_eq("t6b_2", g_obs[2], c_rr ? 1 : 3);
      end

      start = 1'b1; abort = 1'b1; in_vec = 8'hFF;
      step();
      start = 1'b0; abort = 1'b0;
      chk_eq("abort_start_busy", busy, 0);
      chk_eq("abort_start_valid", out_valid, 0);

      for (int t = 0; t < 150; t++) begin
         logic [W-1:0] v;
         v = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         run_scan(v, 0, ($urandom % 6 == 0) ? int'($urandom_range(0, 3)) : -1, 1'b1);
      end

      in_vec32 = 32'h8000_0000; start32 = 1'b1;
      step();
      start32 = 1'b0; in_vec32 = '0;
      chk_eq("t7_valid", valid32, 1);
      chk_eq("t7_idx", idx32, 31);
      ready32 = 1'b1;
      step();
      ready32 = 1'b0;
      chk_eq("t7_done", done32, 1);
      chk_eq("t7_none", none32, 0);
      step();
      chk_eq("t7_busy", busy32, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
